// File: rtl/cpu_hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects, action codes
// and the scoreboard entry layout.
package cpu_hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        ActRun     = 2'd0,
        ActLuStall = 2'd1,
        ActFlush   = 2'd2,
        ActFreeze  = 2'd3
    } action_e;

    localparam int unsigned PC_IDX = 15;

    // Entry packed as {valid, dst[reg_w-1:0], load}; an all-zero entry is a bubble.
    localparam int unsigned SB_LOAD_BIT = 0;
    localparam int unsigned SB_DST_LSB  = 1;

    function automatic int unsigned sb_width(input int unsigned reg_w);
        return reg_w + 2;
    endfunction

    function automatic int unsigned sb_valid_bit(input int unsigned reg_w);
        return reg_w + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot destination scoreboard (EX, MEM, WB) that shifts each cycle unless held,
// with a bubble inserted into EX on request.
module hazard_scoreboard
    import cpu_hazard_pkg::*;
#(
    parameter int unsigned REG_W = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         hold_i,
    input  logic                         bubble_i,
    input  logic [sb_width(REG_W)-1:0]   ex_in_i,
    output logic [sb_width(REG_W)-1:0]   ex_o,
    output logic [sb_width(REG_W)-1:0]   mem_o,
    output logic [sb_width(REG_W)-1:0]   wb_o
);

    localparam int unsigned EntryW = sb_width(REG_W);

    logic [EntryW-1:0] ex_q, ex_d;
    logic [EntryW-1:0] mem_q, mem_d;
    logic [EntryW-1:0] wb_q, wb_d;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!hold_i) begin
            ex_d  = bubble_i ? '0 : ex_in_i;
            mem_d = ex_q;
            wb_d  = mem_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage pipeline: stall, flush, freeze and forwarding selects
// derived from a private destination scoreboard, plus saturating event counters.
module pipeline_hazard_controller
    import cpu_hazard_pkg::*;
#(
    parameter int unsigned REG_W    = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic             id_rf_e,
    input  logic             id_load,
    input  logic [REG_W-1:0] id_dst,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_clear,
    output logic             nop_sel,
    output logic             pipe_enable,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             wait_timeout
);

    localparam int unsigned EntryW   = sb_width(REG_W);
    localparam int unsigned ValidBit = sb_valid_bit(REG_W);
    localparam int unsigned WaitW    = $clog2(MAX_WAIT + 1);
    localparam logic [REG_W-1:0] PcReg   = REG_W'(PC_IDX);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    logic [EntryW-1:0] sb_ex, sb_mem, sb_wb, ex_in;
    action_e           act, action_q;
    logic              lu_hit;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             wait_timeout_q, wait_timeout_d;

    function automatic logic hit(input logic [EntryW-1:0] e, input logic [REG_W-1:0] src);
        return e[ValidBit] && (e[SB_DST_LSB +: REG_W] == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] src,
                                           input logic [EntryW-1:0] ex,
                                           input logic [EntryW-1:0] mem,
                                           input logic [EntryW-1:0] wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && src != PcReg) begin
            // A load in EX has no result yet; fall through to older producers.
            if (hit(ex, src) && !ex[SB_LOAD_BIT]) sel = FWD_EX;
            else if (hit(mem, src))               sel = FWD_MEM;
            else if (hit(wb, src))                sel = FWD_WB;
        end
        return sel;
    endfunction

    assign ex_in  = {id_valid & id_rf_e, id_dst, id_load};
    assign lu_hit = sb_ex[ValidBit] && sb_ex[SB_LOAD_BIT] &&
                    ((id_use_rn && hit(sb_ex, id_rn)) ||
                     (id_use_rm && hit(sb_ex, id_rm)) ||
                     (id_use_rd && hit(sb_ex, id_rd)));

    always_comb begin
        act = ActRun;
        if (!reset)               act = ActRun;
        else if (mem_wait)        act = ActFreeze;
        else if (ex_branch_taken) act = ActFlush;
        else if (lu_hit)          act = ActLuStall;
    end

    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        pipe_enable  = 1'b1;
        nop_sel      = 1'b0;
        if_id_clear  = 1'b0;
        case (act)
            ActFreeze: begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                pipe_enable  = 1'b0;
            end
            ActFlush: begin
                if_id_clear = 1'b1;
                nop_sel     = 1'b1;
            end
            ActLuStall: begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                nop_sel      = 1'b1;
            end
            default: ;
        endcase
    end

    hazard_scoreboard #(
        .REG_W (REG_W)
    ) u_sb (
        .clk_i    (clk),
        .rst_ni   (reset),
        .hold_i   (act == ActFreeze),
        .bubble_i ((act == ActFlush) || (act == ActLuStall)),
        .ex_in_i  (ex_in),
        .ex_o     (sb_ex),
        .mem_o    (sb_mem),
        .wb_o     (sb_wb)
    );

    assign fwd_a = fwd_sel(id_use_rn, id_rn, sb_ex, sb_mem, sb_wb);
    assign fwd_b = fwd_sel(id_use_rm, id_rm, sb_ex, sb_mem, sb_wb);
    assign fwd_c = fwd_sel(id_use_rd, id_rd, sb_ex, sb_mem, sb_wb);

    logic unused_load_bits;
    assign unused_load_bits = sb_mem[SB_LOAD_BIT] ^ sb_wb[SB_LOAD_BIT];

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((act == ActFreeze || act == ActLuStall) && stall_count_q != '1)
            stall_count_d = stall_count_q + CNT_W'(1);
        if (act == ActFlush && flush_count_q != '1)
            flush_count_d = flush_count_q + CNT_W'(1);

        wait_cnt_d = '0;
        if (mem_wait)
            wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
        wait_timeout_d = wait_timeout_q | (wait_cnt_d == WaitMax);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            action_q       <= ActRun;
            stall_count_q  <= '0;
            flush_count_q  <= '0;
            wait_cnt_q     <= '0;
            wait_timeout_q <= 1'b0;
        end else begin
            action_q       <= act;
            stall_count_q  <= stall_count_d;
            flush_count_q  <= flush_count_d;
            wait_cnt_q     <= wait_cnt_d;
            wait_timeout_q <= wait_timeout_d;
        end
    end

    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;
    assign wait_timeout = wait_timeout_q;

endmodule
